// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: main + skid entry, stall/flush, and a
// coprocessor instruction FIFO side-channel. Optional counters: PIPE_STAGE_STAT_EN.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W = 128,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
  parameter int unsigned          PC_W      = 30,
  parameter int unsigned          INSN_W    = 32,
  parameter int unsigned          CP_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         in_cp_req,
  input  logic [INSN_W-1:0]            in_insn,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [PC_W-1:0]              out_pc,
  output logic                         cp_valid,
  input  logic                         cp_ready,
  output logic [INSN_W-1:0]            cp_insn,
  output logic [$clog2(CP_DEPTH):0]    cp_count
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]                  stat_stall_cnt,
  output logic [15:0]                  stat_flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(CP_DEPTH);

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [PC_W-1:0]      main_pc;
  logic                 main_cp_req;
  logic [INSN_W-1:0]    main_insn;

  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [PC_W-1:0]      skid_pc;
  logic                 skid_cp_req;
  logic [INSN_W-1:0]    skid_insn;

  logic [INSN_W-1:0]    cp_mem [CP_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;

  logic cp_full;
  logic accept;
  logic fire;
  logic push;
  logic pop;

  assign cp_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cp_valid  = (wr_ptr != rd_ptr);
  assign cp_count  = wr_ptr - rd_ptr;
  assign cp_insn   = cp_mem[rd_ptr[AW-1:0]];

  assign in_ready    = !skid_valid && !stall;
  assign out_valid   = main_valid && !(main_cp_req && cp_full);
  assign out_payload = main_payload;
  assign out_pc      = main_pc;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready && !stall;
  // A bundle leaving in a flush cycle is killed, so its instruction is not queued.
  assign push   = fire && main_cp_req && !flush;
  assign pop    = cp_valid && cp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid   <= 1'b0;
      main_payload <= NOP_VALUE;
      main_pc      <= '0;
      main_cp_req  <= 1'b0;
      main_insn    <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= NOP_VALUE;
      skid_pc      <= '0;
      skid_cp_req  <= 1'b0;
      skid_insn    <= '0;
    end else if (flush) begin
      main_valid   <= 1'b0;
      main_payload <= NOP_VALUE;
      main_pc      <= '0;
      main_cp_req  <= 1'b0;
      skid_valid   <= 1'b0;
    end else if (!stall) begin
      if (!main_valid || fire) begin
        if (skid_valid) begin
          main_valid   <= 1'b1;
          main_payload <= skid_payload;
          main_pc      <= skid_pc;
          main_cp_req  <= skid_cp_req;
          main_insn    <= skid_insn;
          skid_valid   <= 1'b0;
        end else if (accept) begin
          main_valid   <= 1'b1;
          main_payload <= in_payload;
          main_pc      <= in_pc;
          main_cp_req  <= in_cp_req;
          main_insn    <= in_insn;
        end else begin
          main_valid   <= 1'b0;
        end
      end else if (accept) begin
        skid_valid   <= 1'b1;
        skid_payload <= in_payload;
        skid_pc      <= in_pc;
        skid_cp_req  <= in_cp_req;
        skid_insn    <= in_insn;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) cp_mem[wr_ptr[AW-1:0]] <= main_insn;
  end

`ifdef PIPE_STAGE_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (main_valid && !fire && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (flush)
        stat_flush_cnt <= stat_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic,
// compared against a queue-based model of the stage and the coprocessor FIFO.
module tb_pipe_stage_reg;
  localparam int unsigned PW  = 128;
  localparam int unsigned PCW = 30;
  localparam int unsigned IW  = 32;
  localparam int unsigned D   = 4;
  localparam logic [PW-1:0] NOP = '0;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [PW-1:0]  in_payload = '0;
  logic [PCW-1:0] in_pc = '0;
  logic           in_cp_req = 1'b0;
  logic [IW-1:0]  in_insn = '0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PW-1:0]  out_payload;
  logic [PCW-1:0] out_pc;
  logic           cp_valid;
  logic           cp_ready = 1'b0;
  logic [IW-1:0]  cp_insn;
  logic [$clog2(D):0] cp_count;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]    stat_stall_cnt;
  logic [15:0]    stat_flush_cnt;
`endif

  pipe_stage_reg #(
    .PAYLOAD_W (PW),
    .NOP_VALUE (NOP),
    .PC_W      (PCW),
    .INSN_W    (IW),
    .CP_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_pc       (in_pc),
    .in_cp_req   (in_cp_req),
    .in_insn     (in_insn),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_pc      (out_pc),
    .cp_valid    (cp_valid),
    .cp_ready    (cp_ready),
    .cp_insn     (cp_insn),
    .cp_count    (cp_count)
`ifdef PIPE_STAGE_STAT_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]  p;
    logic [PCW-1:0] pc;
    logic           cp;
    logic [IW-1:0]  insn;
  } bun_t;

  bun_t           pq[$];
  logic [IW-1:0]  cpq[$];
  logic [PW-1:0]  last_p  = NOP;
  logic [PCW-1:0] last_pc = '0;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v, input logic cp, input logic ordy,
                     input logic st, input logic fl, input logic crdy);
    in_valid   = v;
    in_cp_req  = cp;
    out_ready  = ordy;
    stall      = st;
    flush      = fl;
    cp_ready   = crdy;
    in_payload = {$urandom, $urandom, $urandom, $urandom};
    in_pc      = PCW'($urandom);
    in_insn    = $urandom;
  endtask

  // Called at a negedge with inputs applied; checks outputs, advances model one cycle.
  task automatic cycle();
    logic exp_ir, exp_ov, do_fire, do_acc, do_pop;
    bun_t nb;
    #1;
    exp_ir = (pq.size() < 2) && !stall;
    exp_ov = (pq.size() > 0) && !(pq[0].cp && cpq.size() == D);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("out_payload", out_payload, (pq.size() > 0) ? pq[0].p : last_p);
    chk("out_pc", out_pc, (pq.size() > 0) ? pq[0].pc : last_pc);
    chk("cp_valid", cp_valid, cpq.size() > 0);
    chk("cp_count", cp_count, cpq.size());
    if (cpq.size() > 0) chk("cp_insn", cp_insn, cpq[0]);

    do_pop  = (cpq.size() > 0) && cp_ready;
    do_fire = exp_ov && out_ready && !stall;
    do_acc  = in_valid && exp_ir;
    if (do_pop) void'(cpq.pop_front());
    if (flush) begin
      pq.delete();
      last_p  = NOP;
      last_pc = '0;
    end else if (!stall) begin
      if (do_fire) begin
        if (pq[0].cp) cpq.push_back(pq[0].insn);
        last_p  = pq[0].p;
        last_pc = pq[0].pc;
        void'(pq.pop_front());
      end
      if (do_acc) begin
        nb.p = in_payload; nb.pc = in_pc; nb.cp = in_cp_req; nb.insn = in_insn;
        pq.push_back(nb);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_mid();
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_payload", out_payload, NOP);
    chk("rst_cp_count", cp_count, 0);
    chk("rst_cp_valid", cp_valid, 1'b0);
    pq.delete();
    cpq.delete();
    last_p  = NOP;
    last_pc = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      set(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("stream_in_ready", in_ready, 1'b1);
    end
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();

    // Backpressure into the skid entry, then release
    for (int i = 0; i < 3; i++) begin
      set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    chk("skid_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();

    // Coprocessor FIFO fills; fifth bundle is held until one pop
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle();
    for (int i = 0; i < 5; i++) begin
      set(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    chk("full_count", cp_count, 4);
    chk("full_held", out_valid, 1'b0);
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("refill_count", cp_count, 4);

    // Flush during stall with main and skid valid; FIFO still pops
    set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    set(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_payload", out_payload, NOP);
    chk("flush_pop", cp_count, 3);
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Reset mid-stream with two FIFO entries queued
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) cycle();
    for (int i = 0; i < 3; i++) begin
      set(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_count", cp_count, 2);
    reset_mid();
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic fl;
      fl = ($urandom_range(0, 19) == 0);
      set(1'(($urandom_range(0, 3)) != 0), 1'($urandom),
          fl ? 1'b0 : 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 4) == 0), fl, 1'($urandom));
      cycle();
    end

`ifdef PIPE_STAGE_STAT_EN
    reset_mid();
    set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle();
    set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("stat_stall", stat_stall_cnt, 3);
    chk("stat_flush", stat_flush_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer, stall and flush control, and a decoupled coprocessor instruction side-channel.
- Supersedes hand-written per-stage registers (ID/EX, EX/MEM). The payload is one packed control/data bundle whose flush value is a parameter.
- Coprocessor-bound instructions are queued in a FIFO that the coprocessor drains with its own handshake, so the pipeline need not wait on a clock-edge window.

Parameters:
- PAYLOAD_W, 128, width of the packed stage bundle (alu op, operands, mem op, ctrl op, dst addr, we_, exp code, ...).
- NOP_VALUE, {PAYLOAD_W{1'b0}}, bundle value loaded on reset and flush (encodes NOP ops, we_ deasserted, no exception).
- PC_W, 30, width of the word-address PC.
- INSN_W, 32, coprocessor instruction width.
- CP_DEPTH, 4, coprocessor FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; equals !skid_valid && !stall (combinational).
- in_payload  in  PAYLOAD_W  upstream bundle.
- in_pc  in  PC_W  upstream PC.
- in_cp_req  in  1  bundle carries a coprocessor instruction.
- in_insn  in  INSN_W  raw instruction word.
- stall  in  1  freeze all state.
- flush  in  1  synchronous kill of in-flight bundles.
- out_valid  out  1  main_valid && !(main_cp_req && cp_full).
- out_ready  in  1  downstream accepts.
- out_payload  out  PAYLOAD_W  registered bundle.
- out_pc  out  PC_W  registered PC.
- cp_valid  out  1  FIFO not empty.
- cp_ready  in  1  coprocessor pops.
- cp_insn  out  INSN_W  FIFO head (show-ahead).
- cp_count  out  $clog2(CP_DEPTH)+1  FIFO occupancy.

Behaviour:
- **Reset values:** out_valid=0, out_payload=NOP_VALUE, out_pc=0, main/skid entries invalid, FIFO pointers=0, cp_valid=0, cp_count=0. cp_insn reads the (don't-care) head slot while cp_valid=0. With stall low after reset, in_ready=1.
- **Handshake events:**
  - accept = in_valid && in_ready.
  - fire = out_valid && out_ready && !stall.
  - pop = cp_valid && cp_ready.
- **Priority:** reset > flush > stall > normal operation.
- **Flush:**
  - Clears main_valid and skid_valid.
  - Loads NOP_VALUE into out_payload and 0 into out_pc.
  - Ignores in_valid that cycle.
  - Takes effect even while stall is high.
  - The FIFO is NOT flushed (entries are already committed). pop is still honoured in a flush cycle.
- **Stall:** main, skid and FIFO push state hold. in_ready=0. FIFO pop continues (the coprocessor runs independently).
- **Main entry update:** when main is empty or fire occurs:
  - If skid is valid, main takes skid and skid clears.
  - Otherwise, if accept, main takes the input.
  - Otherwise main_valid=0 and the payload holds.
- **Skid entry:** when main is valid, fire=0 and accept=1, the input goes into skid. Skid drains into main before any new input is taken, so ordering is preserved.
- **Latency and throughput:**
  - Latency is 1 cycle input-to-output when empty.
  - Full throughput of 1 bundle/cycle when out_ready is held high.
  - in_ready drops exactly one cycle after the first out_ready-low cycle that has a valid input.
- **FIFO push:** on fire with main_cp_req=1, write main_insn.
  - Cannot occur while full, because out_valid is gated low.
  - Push and pop in the same cycle leave cp_count unchanged.
  - Pointers are $clog2(CP_DEPTH)+1 bits; full/empty use the MSB-differ compare and wrap modulo 2*CP_DEPTH.

Optional Feature:
- Macro PIPE_STAGE_STAT_EN.
- Defined: adds outputs stat_stall_cnt [31:0] (increments on each cycle with main_valid && !fire, saturating at 32'hFFFF_FFFF) and stat_flush_cnt [15:0] (increments per flush cycle, wraps). Both reset to 0 and are not cleared by flush.
- Undefined: no counters and no extra ports.

Test Plan:
1. Reset mid-stream with out_valid=1 and 2 FIFO entries queued -> same cycle: out_valid=0, out_payload=NOP_VALUE, cp_count=0, cp_valid=0.
2. Stream 8 bundles with out_ready=1 -> each emerges 1 cycle later in order; in_ready stays 1.
3. Hold out_ready=0 for 3 cycles while streaming in -> second bundle lands in skid, in_ready=0. Release -> bundles A,B,C emerge on consecutive cycles, no loss or duplication.
4. Assert flush together with stall while main and skid are valid -> next cycle both invalid, out_payload=NOP_VALUE; a FIFO entry pops if cp_ready=1.
5. CP_DEPTH=4 with cp_ready=0 and 5 bundles all cp_req=1 -> cp_count=4, the 5th is held with out_valid=0. Pulse cp_ready for 1 cycle -> the 5th fires next cycle and cp_count returns to 4.
6. With PIPE_STAGE_STAT_EN: 3 backpressured cycles plus 2 flush cycles -> stat_stall_cnt=3, stat_flush_cnt=2.
